// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the 32-bit MIPS core.
// Owns the word-addressed fetch PC and issues one request at a time to
// instruction memory over a req/ack handshake. Each returned instruction is
// presented to decode and held while decode stalls. Once decode consumes it,
// the next PC is chosen: sequential, jump, jump-register, taken branch or flush.
// A request that goes unanswered for MAX_WAIT cycles parks the block in a
// sticky error state. Only reset leaves that state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | one idle cycle after reset before the first request
// S_REQ   | request outstanding at fetch_pc_q, counting wait cycles
// S_VALID | instruction presented to decode, waiting for consume
// S_ERR   | memory timeout, FetchErr held until reset
module fetch_sequencer #(
  parameter int unsigned              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0,
  parameter int unsigned              MAX_WAIT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [31:0]       ImemData,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              Jump,
  input  logic              JumpReg,
  input  logic              Branch,
  input  logic              AluZero,
  input  logic [ADDR_W-1:0] Target,
  output logic [31:0]       InstrOut,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PcOut,
  output logic              FetchErr
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [31:0]       instr_q;
  logic [CNT_W-1:0]  wait_q;
  logic              req_q;
  logic              valid_q;
  logic              err_q;

  logic              redirect;
  logic [ADDR_W-1:0] consume_pc_d;
  logic [CNT_W-1:0]  wait_d;

  // Next fetch address when decode consumes the presented instruction; the
  // increment wraps modulo 2^ADDR_W with no carry kept.
  always_comb begin
    redirect     = Jump | JumpReg | (Branch & AluZero);
    consume_pc_d = redirect ? Target : (pc_out_q + ADDR_W'(1));
    wait_d       = wait_q + CNT_W'(1);
  end

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      pc_out_q   <= RESET_PC;
      instr_q    <= '0;
      wait_q     <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          wait_q  <= '0;
        end
        S_REQ: begin
          if (Flush) begin
            // A response landing together with the flush belongs to the old
            // address and is dropped.
            fetch_pc_q <= Target;
            wait_q     <= '0;
          end else if (ImemAck) begin
            instr_q  <= ImemData;
            pc_out_q <= fetch_pc_q;
            wait_q   <= '0;
            state_q  <= S_VALID;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
          end else if (wait_d == WAIT_LIMIT) begin
            wait_q  <= wait_d;
            state_q <= S_ERR;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_d;
          end
        end
        S_VALID: begin
          if (Flush) begin
            fetch_pc_q <= Target;
            wait_q     <= '0;
            state_q    <= S_REQ;
            valid_q    <= 1'b0;
            req_q      <= 1'b1;
          end else if (!Stall) begin
            fetch_pc_q <= consume_pc_d;
            wait_q     <= '0;
            state_q    <= S_REQ;
            valid_q    <= 1'b0;
            req_q      <= 1'b1;
          end
        end
        S_ERR: begin
          // Sticky until reset; Flush has no effect here.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ImemReq    = req_q;
  assign ImemAddr   = fetch_pc_q;
  assign InstrOut   = instr_q;
  assign InstrValid = valid_q;
  assign PcOut      = pc_out_q;
  assign FetchErr   = err_q;

endmodule
